// File: rtl/tcdm_port_slice_pkg.sv
// Shared defaults and request-entry layout for the TCDM port slice.
package tcdm_port_slice_package;

  localparam int unsigned MP_DEF        = 4;
  localparam int unsigned DEPTH_DEF     = 2;
  localparam int unsigned MAX_OUTST_DEF = 4;
  localparam int unsigned DW_DEF        = 32;
  localparam int unsigned AW            = 32;
  localparam int unsigned CNT_W         = 4;

  typedef struct packed {
    logic [AW-1:0]       add;
    logic                wen;
    logic [DW_DEF/8-1:0] be;
    logic [DW_DEF-1:0]   data;
  } req_entry_t;

endpackage

// File: rtl/tcdm_port_slice_fifo.sv
// Per-port request FIFO with outstanding-transaction limiter and
// unexpected-response detection.
module tcdm_slice_fifo
  import tcdm_port_slice_package::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF,
  parameter int unsigned DW        = DW_DEF
)(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              in_req,
  output logic              in_gnt,
  input  logic [AW-1:0]     in_add,
  input  logic              in_wen,
  input  logic [DW/8-1:0]   in_be,
  input  logic [DW-1:0]     in_data,
  output logic              out_req,
  input  logic              out_gnt,
  output logic [AW-1:0]     out_add,
  output logic              out_wen,
  output logic [DW/8-1:0]   out_be,
  output logic [DW-1:0]     out_data,
  input  logic              rsp_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned PW = $clog2(DEPTH);

  // Same layout as req_entry_t, widened to this instance's data width.
  typedef struct packed {
    logic [AW-1:0]     add;
    logic              wen;
    logic [DW/8-1:0]   be;
    logic [DW-1:0]     data;
  } entry_t;

  entry_t           mem_r [DEPTH];
  entry_t           head_s;
  logic [PW:0]      wr_ptr_r;
  logic [PW:0]      rd_ptr_r;
  logic [CNT_W-1:0] outst_r;
  logic             err_r;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                    (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign in_gnt   = ~full_s & ~clear_i;
  assign push_s   = in_req & in_gnt;
  assign out_req  = ~empty_s & (outst_r < CNT_W'(MAX_OUTST));
  assign pop_s    = out_req & out_gnt;
  assign head_s   = mem_r[rd_ptr_r[PW-1:0]];
  assign out_add  = head_s.add;
  assign out_wen  = head_s.wen;
  assign out_be   = head_s.be;
  assign out_data = head_s.data;
  assign busy     = ~empty_s | (outst_r != '0);
  assign err      = err_r;

  // Pointer update; clear drops everything still queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= '{add: in_add, wen: in_wen, be: in_be, data: in_data};
    end
  end

  // Outstanding counter; a response with nothing in flight flags an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_r <= '0;
      err_r   <= 1'b0;
    end else begin
      case ({pop_s, rsp_valid})
        2'b10:   outst_r <= outst_r + CNT_W'(1);
        2'b01: begin
          if (outst_r == '0) err_r   <= 1'b1;
          else               outst_r <= outst_r - CNT_W'(1);
        end
        default: outst_r <= outst_r;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_port_slice.sv
// MP independent TCDM request slices with a registered response path.
module tcdm_port_slice
  import tcdm_port_slice_package::*;
#(
  parameter int unsigned MP        = MP_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF,
  parameter int unsigned DW        = DW_DEF
)(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [MP-1:0]              acc_req,
  output logic [MP-1:0]              acc_gnt,
  input  logic [MP-1:0][AW-1:0]      acc_add,
  input  logic [MP-1:0]              acc_wen,
  input  logic [MP-1:0][DW/8-1:0]    acc_be,
  input  logic [MP-1:0][DW-1:0]      acc_data,
  output logic [MP-1:0][DW-1:0]      acc_r_data,
  output logic [MP-1:0]              acc_r_valid,
  output logic [MP-1:0]              tcdm_req,
  input  logic [MP-1:0]              tcdm_gnt,
  output logic [MP-1:0][AW-1:0]      tcdm_add,
  output logic [MP-1:0]              tcdm_wen,
  output logic [MP-1:0][DW/8-1:0]    tcdm_be,
  output logic [MP-1:0][DW-1:0]      tcdm_data,
  input  logic [MP-1:0][DW-1:0]      tcdm_r_data,
  input  logic [MP-1:0]              tcdm_r_valid,
  output logic                       busy_o,
  output logic [MP-1:0]              err_o
);

  logic [MP-1:0]         busy_s;
  logic [MP-1:0]         acc_r_valid_r;
  logic [MP-1:0][DW-1:0] acc_r_data_r;

  for (genvar g = 0; g < int'(MP); g++) begin : g_port
    tcdm_slice_fifo #(
      .DEPTH     (DEPTH),
      .MAX_OUTST (MAX_OUTST),
      .DW        (DW)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .in_req    (acc_req[g]),
      .in_gnt    (acc_gnt[g]),
      .in_add    (acc_add[g]),
      .in_wen    (acc_wen[g]),
      .in_be     (acc_be[g]),
      .in_data   (acc_data[g]),
      .out_req   (tcdm_req[g]),
      .out_gnt   (tcdm_gnt[g]),
      .out_add   (tcdm_add[g]),
      .out_wen   (tcdm_wen[g]),
      .out_be    (tcdm_be[g]),
      .out_data  (tcdm_data[g]),
      .rsp_valid (tcdm_r_valid[g]),
      .busy      (busy_s[g]),
      .err       (err_o[g])
    );
  end

  // One-cycle response register; data holds between valid beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_r_valid_r <= '0;
      acc_r_data_r  <= '0;
    end else begin
      acc_r_valid_r <= tcdm_r_valid;
      for (int i = 0; i < int'(MP); i++) begin
        if (tcdm_r_valid[i]) acc_r_data_r[i] <= tcdm_r_data[i];
      end
    end
  end

  assign acc_r_valid = acc_r_valid_r;
  assign acc_r_data  = acc_r_data_r;
  assign busy_o      = (|busy_s) | (|acc_r_valid_r);

endmodule

// File: tb/tb_tcdm_port_slice.sv
// Self-checking bench for tcdm_port_slice: directed scenarios plus random traffic
// against a queue-based transaction model.
module tb_tcdm_port_slice;

  localparam int MP    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int MAXO  = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    clear_i;
  logic [MP-1:0]           acc_req;
  logic [MP-1:0]           acc_gnt;
  logic [MP-1:0][31:0]     acc_add;
  logic [MP-1:0]           acc_wen;
  logic [MP-1:0][DW/8-1:0] acc_be;
  logic [MP-1:0][DW-1:0]   acc_data;
  logic [MP-1:0][DW-1:0]   acc_r_data;
  logic [MP-1:0]           acc_r_valid;
  logic [MP-1:0]           tcdm_req;
  logic [MP-1:0]           tcdm_gnt;
  logic [MP-1:0][31:0]     tcdm_add;
  logic [MP-1:0]           tcdm_wen;
  logic [MP-1:0][DW/8-1:0] tcdm_be;
  logic [MP-1:0][DW-1:0]   tcdm_data;
  logic [MP-1:0][DW-1:0]   tcdm_r_data;
  logic [MP-1:0]           tcdm_r_valid;
  logic                    busy_o;
  logic [MP-1:0]           err_o;

  int total = 0;
  int bad   = 0;

  tcdm_port_slice #(.MP(MP), .DEPTH(DEPTH), .MAX_OUTST(MAXO), .DW(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .acc_req(acc_req), .acc_gnt(acc_gnt), .acc_add(acc_add), .acc_wen(acc_wen),
    .acc_be(acc_be), .acc_data(acc_data), .acc_r_data(acc_r_data), .acc_r_valid(acc_r_valid),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
    .tcdm_r_valid(tcdm_r_valid), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] rsp_of(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic idle();
    acc_req = '0; acc_add = '0; acc_wen = '0; acc_be = '1; acc_data = '0;
    tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0; clear_i = 1'b0;
  endtask

  // Grants everything and answers every grant (plus 'owed' earlier ones) until idle.
  task automatic drain(input int o0, input int o1, input int o2, input int o3);
    int owed [MP];
    bit done;
    owed = '{o0, o1, o2, o3};
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk_i);
      acc_req = '0; clear_i = 1'b0; tcdm_gnt = '1;
      for (int i = 0; i < MP; i++) begin
        tcdm_r_valid[i] = (owed[i] > 0);
        if (owed[i] > 0) owed[i]--;
      end
      #1;
      for (int i = 0; i < MP; i++) if (tcdm_req[i]) owed[i]++;
      if (busy_o === 1'b0 && tcdm_r_valid == '0 && owed[0] + owed[1] + owed[2] + owed[3] == 0)
        done = 1'b1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL drain_timeout busy=%b required 0", busy_o); end
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if (tcdm_req !== 4'b0000 || busy_o !== 1'b0 || err_o !== 4'b0000 || acc_r_valid !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state req=%b busy=%b err=%b rvalid=%b required all 0",
               tcdm_req, busy_o, err_o, acc_r_valid);
    end
    total++;
    if (acc_r_data !== '0) begin bad++; $display("FAIL reset_rdata got=%h required 0", acc_r_data); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++;
    if (acc_gnt !== 4'b1111) begin bad++; $display("FAIL reset_gnt got=%b required 1111", acc_gnt); end
  endtask

  task automatic test_single_read();
    idle();
    @(negedge clk_i);
    acc_req[0] = 1'b1; acc_add[0] = 32'h0000_0100; acc_wen[0] = 1'b1;
    #1;
    total++;
    if (acc_gnt[0] !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%b required 1", acc_gnt[0]); end
    @(negedge clk_i);
    acc_req[0] = 1'b0; tcdm_gnt[0] = 1'b1;
    #1;
    total++;
    if (tcdm_req[0] !== 1'b1 || tcdm_add[0] !== 32'h0000_0100 || tcdm_wen[0] !== 1'b1) begin
      bad++;
      $display("FAIL rd_issue req=%b add=%h wen=%b required 1/00000100/1", tcdm_req[0], tcdm_add[0], tcdm_wen[0]);
    end
    @(negedge clk_i);
    tcdm_gnt[0] = 1'b0; tcdm_r_valid[0] = 1'b1; tcdm_r_data[0] = 32'hDEAD_BEEF;
    #1;
    total++;
    if (tcdm_req[0] !== 1'b0 || acc_r_valid[0] !== 1'b0) begin
      bad++; $display("FAIL rd_t2 req=%b rvalid=%b required 0/0", tcdm_req[0], acc_r_valid[0]);
    end
    @(negedge clk_i);
    tcdm_r_valid[0] = 1'b0; tcdm_r_data[0] = 32'h0;
    #1;
    total++;
    if (acc_r_valid[0] !== 1'b1 || acc_r_data[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL rd_resp valid=%b data=%h required 1/deadbeef", acc_r_valid[0], acc_r_data[0]);
    end
    @(negedge clk_i);
    #1;
    total++;
    if (acc_r_valid[0] !== 1'b0 || acc_r_data[0] !== 32'hDEAD_BEEF || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL rd_hold valid=%b data=%h busy=%b required 0/deadbeef/0", acc_r_valid[0], acc_r_data[0], busy_o);
    end
  endtask

  task automatic test_backpressure();
    idle();
    @(negedge clk_i);
    acc_req[0] = 1'b1; acc_wen[0] = 1'b0; acc_add[0] = 32'h1000;
    #1;
    total++;
    if (acc_gnt[0] !== 1'b1) begin bad++; $display("FAIL bp_gnt1 got=%b required 1", acc_gnt[0]); end
    @(negedge clk_i);
    acc_add[0] = 32'h1004;
    #1;
    total++;
    if (acc_gnt[0] !== 1'b1 || tcdm_req[0] !== 1'b1 || tcdm_add[0] !== 32'h1000) begin
      bad++; $display("FAIL bp_gnt2 gnt=%b req=%b add=%h required 1/1/1000", acc_gnt[0], tcdm_req[0], tcdm_add[0]);
    end
    @(negedge clk_i);
    acc_add[0] = 32'h1008;
    #1;
    total++;
    if (acc_gnt[0] !== 1'b0) begin bad++; $display("FAIL bp_full gnt=%b required 0", acc_gnt[0]); end
    @(negedge clk_i);
    tcdm_gnt[0] = 1'b1;
    #1;
    total++;
    if (acc_gnt[0] !== 1'b0 || tcdm_add[0] !== 32'h1000) begin
      bad++; $display("FAIL bp_stable gnt=%b add=%h required 0/1000", acc_gnt[0], tcdm_add[0]);
    end
    @(negedge clk_i);
    tcdm_gnt[0] = 1'b0;
    #1;
    total++;
    if (acc_gnt[0] !== 1'b1 || tcdm_add[0] !== 32'h1004) begin
      bad++; $display("FAIL bp_third gnt=%b add=%h required 1/1004", acc_gnt[0], tcdm_add[0]);
    end
    @(negedge clk_i);
    acc_req[0] = 1'b0;
    #1;
    total++;
    if (tcdm_add[0] !== 32'h1004 || acc_gnt[0] !== 1'b0) begin
      bad++; $display("FAIL bp_after head=%h gnt=%b required 1004/0", tcdm_add[0], acc_gnt[0]);
    end
    drain(1, 0, 0, 0);
  endtask

  task automatic test_max_outst();
    int grants;
    idle();
    tcdm_gnt[1] = 1'b1;
    grants = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      acc_req[1] = 1'b1; acc_add[1] = 32'h2000 + 32'(4 * k);
      #1;
      if (tcdm_req[1]) grants++;
    end
    total++;
    if (grants !== MAXO || tcdm_req[1] !== 1'b0) begin
      bad++; $display("FAIL outst_limit grants=%0d req=%b required %0d/0", grants, tcdm_req[1], MAXO);
    end
    @(negedge clk_i);
    acc_req[1] = 1'b0; tcdm_r_valid[1] = 1'b1;
    #1;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      tcdm_r_valid[1] = 1'b0;
      #1;
      if (tcdm_req[1]) grants++;
    end
    total++;
    if (grants !== 1) begin bad++; $display("FAIL outst_release grants=%0d required 1", grants); end
    drain(0, MAXO, 0, 0);
  endtask

  task automatic test_clear();
    idle();
    @(negedge clk_i);
    acc_req[3] = 1'b1; acc_add[3] = 32'h3000;
    #1;
    @(negedge clk_i);
    acc_add[3] = 32'h3004; tcdm_gnt[3] = 1'b1;
    #1;
    @(negedge clk_i);
    acc_add[3] = 32'h3008;
    #1;
    @(negedge clk_i);
    acc_add[3] = 32'h300C; tcdm_gnt[3] = 1'b0;
    #1;
    @(negedge clk_i);
    acc_add[3] = 32'h3010; clear_i = 1'b1;
    #1;
    total++;
    if (acc_gnt[3] !== 1'b0 || tcdm_req[3] !== 1'b1) begin
      bad++; $display("FAIL clr_cycle gnt=%b req=%b required 0/1", acc_gnt[3], tcdm_req[3]);
    end
    @(negedge clk_i);
    acc_req[3] = 1'b0; clear_i = 1'b0;
    tcdm_r_valid[3] = 1'b1; tcdm_r_data[3] = 32'h1111_1111;
    #1;
    total++;
    if (tcdm_req[3] !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL clr_empty req=%b busy=%b required 0/1", tcdm_req[3], busy_o);
    end
    @(negedge clk_i);
    tcdm_r_data[3] = 32'h2222_2222;
    #1;
    total++;
    if (acc_r_valid[3] !== 1'b1 || acc_r_data[3] !== 32'h1111_1111) begin
      bad++; $display("FAIL clr_rsp1 valid=%b data=%h required 1/11111111", acc_r_valid[3], acc_r_data[3]);
    end
    @(negedge clk_i);
    tcdm_r_valid[3] = 1'b0;
    #1;
    total++;
    if (acc_r_valid[3] !== 1'b1 || acc_r_data[3] !== 32'h2222_2222 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL clr_rsp2 valid=%b data=%h busy=%b required 1/22222222/1", acc_r_valid[3], acc_r_data[3], busy_o);
    end
    @(negedge clk_i);
    #1;
    total++;
    if (acc_r_valid[3] !== 1'b0 || busy_o !== 1'b0 || err_o !== 4'b0000) begin
      bad++; $display("FAIL clr_idle valid=%b busy=%b err=%b required 0/0/0000", acc_r_valid[3], busy_o, err_o);
    end
  endtask

  task automatic test_err();
    idle();
    @(negedge clk_i);
    tcdm_r_valid[2] = 1'b1;
    #1;
    @(negedge clk_i);
    tcdm_r_valid[2] = 1'b0;
    #1;
    total++;
    if (err_o !== 4'b0100) begin bad++; $display("FAIL err_set got=%b required 0100", err_o); end
    repeat (3) @(negedge clk_i);
    #1;
    total++;
    if (err_o !== 4'b0100 || busy_o !== 1'b0) begin
      bad++; $display("FAIL err_sticky err=%b busy=%b required 0100/0", err_o, busy_o);
    end
    @(negedge clk_i);
    acc_req[2] = 1'b1; acc_add[2] = 32'h4000; acc_wen[2] = 1'b1;
    #1;
    drain(0, 0, 0, 0);
    total++;
    if (err_o !== 4'b0100) begin bad++; $display("FAIL err_after got=%b required 0100", err_o); end
  endtask

  task automatic test_midreset();
    idle();
    @(negedge clk_i);
    acc_req[0] = 1'b1; acc_add[0] = 32'h5000; acc_req[1] = 1'b1; acc_add[1] = 32'h6000;
    #1;
    @(negedge clk_i);
    acc_add[0] = 32'h5004; tcdm_gnt[0] = 1'b1;
    #1;
    @(negedge clk_i);
    idle();
    rst_ni = 1'b0;
    #1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++;
    if (tcdm_req !== 4'b0000 || busy_o !== 1'b0 || acc_gnt !== 4'b1111) begin
      bad++; $display("FAIL midrst_state req=%b busy=%b gnt=%b required 0000/0/1111", tcdm_req, busy_o, acc_gnt);
    end
    repeat (3) @(negedge clk_i);
    #1;
    total++;
    if (acc_r_valid !== 4'b0000 || busy_o !== 1'b0) begin
      bad++; $display("FAIL midrst_quiet rvalid=%b busy=%b required 0000/0", acc_r_valid, busy_o);
    end
  endtask

  // Transaction model state for the random test.
  logic [68:0] rq    [MP][$];
  logic [31:0] expq  [MP][$];
  logic [31:0] rdq   [MP][$];
  int          dueq  [MP][$];
  int          last_due [MP];
  int          outm  [MP];
  logic [68:0] pend  [MP];
  bit          pend_v[MP];
  logic [MP-1:0] rv_prev;

  task automatic test_random(input int n);
    logic [68:0] head;
    logic [31:0] exp_d;
    bit          exp_req;
    int          due;
    idle();
    rv_prev = '0;
    for (int i = 0; i < MP; i++) begin
      rq[i].delete(); expq[i].delete(); rdq[i].delete(); dueq[i].delete();
      last_due[i] = -1; outm[i] = 0; pend_v[i] = 1'b0; pend[i] = '0;
    end
    for (int cyc = 0; cyc < n + 300; cyc++) begin
      @(negedge clk_i);
      for (int i = 0; i < MP; i++) begin
        if (cyc < n && !pend_v[i] && $urandom_range(0, 99) < 60) begin
          pend[i] = {$urandom, $urandom, 5'($urandom)};
          pend_v[i] = 1'b1;
        end
        acc_req[i] = pend_v[i];
        {acc_add[i], acc_wen[i], acc_be[i], acc_data[i]} = pend[i];
        tcdm_gnt[i] = ($urandom_range(0, 99) < 65);
        if (dueq[i].size() > 0 && dueq[i][0] <= cyc) begin
          tcdm_r_valid[i] = 1'b1;
          tcdm_r_data[i]  = rdq[i].pop_front();
          void'(dueq[i].pop_front());
        end else begin
          tcdm_r_valid[i] = 1'b0;
          tcdm_r_data[i]  = $urandom;
        end
      end
      #1;
      for (int i = 0; i < MP; i++) begin
        total++;
        if (acc_r_valid[i] !== rv_prev[i]) begin
          bad++; $display("FAIL rnd_rvalid port=%0d cyc=%0d got=%b required %b", i, cyc, acc_r_valid[i], rv_prev[i]);
        end
        if (acc_r_valid[i] === 1'b1) begin
          total++;
          if (expq[i].size() == 0) begin
            bad++; $display("FAIL rnd_extra_rsp port=%0d cyc=%0d data=%h required none", i, cyc, acc_r_data[i]);
          end else begin
            exp_d = expq[i].pop_front();
            if (acc_r_data[i] !== exp_d) begin
              bad++; $display("FAIL rnd_rdata port=%0d cyc=%0d got=%h required %h", i, cyc, acc_r_data[i], exp_d);
            end
          end
        end
        total++;
        if (acc_gnt[i] !== (rq[i].size() < DEPTH)) begin
          bad++; $display("FAIL rnd_gnt port=%0d cyc=%0d got=%b occupancy=%0d", i, cyc, acc_gnt[i], rq[i].size());
        end
        exp_req = (rq[i].size() > 0) && (outm[i] < MAXO);
        total++;
        if (tcdm_req[i] !== exp_req) begin
          bad++; $display("FAIL rnd_req port=%0d cyc=%0d got=%b required %b", i, cyc, tcdm_req[i], exp_req);
        end
        if (tcdm_req[i] === 1'b1 && tcdm_gnt[i] === 1'b1) begin
          head = {tcdm_add[i], tcdm_wen[i], tcdm_be[i], tcdm_data[i]};
          total++;
          if (rq[i].size() == 0 || head !== rq[i][0]) begin
            bad++; $display("FAIL rnd_order port=%0d cyc=%0d got=%h", i, cyc, head);
          end
          if (rq[i].size() > 0) void'(rq[i].pop_front());
          outm[i]++;
          due = cyc + $urandom_range(1, 4);
          if (due <= last_due[i]) due = last_due[i] + 1;
          last_due[i] = due;
          dueq[i].push_back(due);
          rdq[i].push_back(rsp_of(tcdm_add[i]));
        end
        if (acc_req[i] && acc_gnt[i] === 1'b1) begin
          rq[i].push_back(pend[i]);
          expq[i].push_back(rsp_of(pend[i][68:37]));
          pend_v[i] = 1'b0;
        end
        if (tcdm_r_valid[i]) outm[i]--;
        rv_prev[i] = tcdm_r_valid[i];
      end
    end
    @(negedge clk_i);
    idle();
    repeat (2) @(negedge clk_i);
    #1;
    for (int i = 0; i < MP; i++) begin
      total++;
      if (rq[i].size() != 0 || expq[i].size() != 0 || dueq[i].size() != 0 || pend_v[i]) begin
        bad++;
        $display("FAIL rnd_leftover port=%0d rq=%0d exp=%0d due=%0d required 0", i, rq[i].size(), expq[i].size(), dueq[i].size());
      end
    end
    total++;
    if (err_o !== 4'b0000 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rnd_final err=%b busy=%b required 0000/0", err_o, busy_o);
    end
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    test_reset();
    test_single_read();
    test_backpressure();
    test_max_outst();
    test_clear();
    test_err();
    test_reset();
    test_midreset();
    test_random(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
